// File: rtl/raizing_textvram_arbiter.sv
// Arbitrates one single-port text VRAM between the extra-text line renderer and the CPU.
// Renderer has default priority; a starvation counter forces a CPU slot after STARVE_MAX losses.
module raizing_textvram_arbiter #(
    parameter int AW         = 12,
    parameter int DW         = 16,
    parameter int RD_LAT     = 2,
    parameter int STARVE_MAX = 8
) (
    input  logic          CLK96,
    input  logic          RESET96,

    input  logic          REN_REQ,
    input  logic [AW-1:0] REN_ADDR,
    output logic          REN_GNT,
    output logic          REN_VALID,
    output logic [DW-1:0] REN_DATA,

    input  logic          CPU_REQ,
    input  logic          CPU_WE,
    input  logic [AW-1:0] CPU_ADDR,
    input  logic [DW-1:0] CPU_DIN,
    input  logic [1:0]    CPU_BE,
    output logic          CPU_ACK,
    output logic [DW-1:0] CPU_DOUT,

    output logic [AW-1:0] MEM_ADDR,
    output logic          MEM_WE,
    output logic [1:0]    MEM_BE,
    output logic [DW-1:0] MEM_DIN,
    input  logic [DW-1:0] MEM_DOUT
);

    localparam logic [7:0] STARVE_LIM = 8'(STARVE_MAX);

    typedef enum logic {
        CPU_IDLE,
        CPU_BUSY
    } cpu_state_t;

    cpu_state_t      cpu_state;
    cpu_state_t      cpu_state_next;

    logic            cpu_eligible;
    logic            cpu_force;
    logic            cpu_win;
    logic            ren_win;
    logic            rd_issue;
    logic [7:0]      starve_cnt;
    logic            wr_ack;

    // Read tags; stage k is visible k+1 cycles after the grant cycle.
    logic [RD_LAT:0] pipe_v;
    logic [RD_LAT:0] pipe_cpu;

    always_comb begin
        cpu_eligible = CPU_REQ && (cpu_state == CPU_IDLE) && !CPU_ACK;
        cpu_force    = cpu_eligible && (starve_cnt == STARVE_LIM);
        cpu_win      = cpu_force || (cpu_eligible && !REN_REQ);
        ren_win      = REN_REQ && !cpu_win;
        rd_issue     = ren_win || (cpu_win && !CPU_WE);
    end

    assign REN_GNT   = ren_win;
    assign REN_VALID = pipe_v[RD_LAT] && !pipe_cpu[RD_LAT];
    assign CPU_ACK   = wr_ack || (pipe_v[RD_LAT] && pipe_cpu[RD_LAT]);

    always_ff @(posedge CLK96) begin
        if (RESET96) begin
            cpu_state <= CPU_IDLE;
        end else begin
            cpu_state <= cpu_state_next;
        end
    end

    always_comb begin
        cpu_state_next = cpu_state;
        case (cpu_state)
            CPU_IDLE: if (cpu_win) cpu_state_next = CPU_BUSY;
            CPU_BUSY: if (CPU_ACK) cpu_state_next = CPU_IDLE;
            default:  cpu_state_next = CPU_IDLE;
        endcase
    end

    always_ff @(posedge CLK96) begin
        if (RESET96) begin
            MEM_ADDR <= '0;
            MEM_WE   <= 1'b0;
            MEM_BE   <= '0;
            MEM_DIN  <= '0;
        end else begin
            MEM_WE <= 1'b0;
            if (cpu_win) begin
                MEM_ADDR <= CPU_ADDR;
                MEM_WE   <= CPU_WE;
                MEM_BE   <= CPU_BE;
                MEM_DIN  <= CPU_DIN;
            end else if (ren_win) begin
                MEM_ADDR <= REN_ADDR;
                MEM_BE   <= 2'b11;
            end
        end
    end

    // Data is sampled one stage before the tag reaches the output stage.
    always_ff @(posedge CLK96) begin
        if (RESET96) begin
            pipe_v   <= '0;
            pipe_cpu <= '0;
            wr_ack   <= 1'b0;
            REN_DATA <= '0;
            CPU_DOUT <= '0;
        end else begin
            pipe_v   <= {pipe_v[RD_LAT-1:0], rd_issue};
            pipe_cpu <= {pipe_cpu[RD_LAT-1:0], cpu_win};
            wr_ack   <= cpu_win && CPU_WE;
            if (pipe_v[RD_LAT-1]) begin
                if (pipe_cpu[RD_LAT-1]) begin
                    CPU_DOUT <= MEM_DOUT;
                end else begin
                    REN_DATA <= MEM_DOUT;
                end
            end
        end
    end

    always_ff @(posedge CLK96) begin
        if (RESET96) begin
            starve_cnt <= '0;
        end else if (!CPU_REQ || cpu_win) begin
            starve_cnt <= '0;
        end else if (cpu_eligible && (starve_cnt < STARVE_LIM)) begin
            starve_cnt <= starve_cnt + 8'd1;
        end
    end

endmodule

// File: tb/tb_raizing_textvram_arbiter.sv
// Directed bench for raizing_textvram_arbiter with a byte-enabled synchronous RAM model.
module tb_raizing_textvram_arbiter;

    logic        CLK96 = 1'b0;
    logic        RESET96 = 1'b1;
    logic        REN_REQ = 1'b0;
    logic [11:0] REN_ADDR = '0;
    logic        REN_GNT;
    logic        REN_VALID;
    logic [15:0] REN_DATA;
    logic        CPU_REQ = 1'b0;
    logic        CPU_WE = 1'b0;
    logic [11:0] CPU_ADDR = '0;
    logic [15:0] CPU_DIN = '0;
    logic [1:0]  CPU_BE = '0;
    logic        CPU_ACK;
    logic [15:0] CPU_DOUT;
    logic [11:0] MEM_ADDR;
    logic        MEM_WE;
    logic [1:0]  MEM_BE;
    logic [15:0] MEM_DIN;
    logic [15:0] MEM_DOUT;

    int checks = 0;
    int errors = 0;

    logic [15:0] mem [0:4095];
    logic [15:0] pat [0:3];

    raizing_textvram_arbiter #(
        .AW(12),
        .DW(16),
        .RD_LAT(2),
        .STARVE_MAX(8)
    ) dut (
        .CLK96(CLK96),
        .RESET96(RESET96),
        .REN_REQ(REN_REQ),
        .REN_ADDR(REN_ADDR),
        .REN_GNT(REN_GNT),
        .REN_VALID(REN_VALID),
        .REN_DATA(REN_DATA),
        .CPU_REQ(CPU_REQ),
        .CPU_WE(CPU_WE),
        .CPU_ADDR(CPU_ADDR),
        .CPU_DIN(CPU_DIN),
        .CPU_BE(CPU_BE),
        .CPU_ACK(CPU_ACK),
        .CPU_DOUT(CPU_DOUT),
        .MEM_ADDR(MEM_ADDR),
        .MEM_WE(MEM_WE),
        .MEM_BE(MEM_BE),
        .MEM_DIN(MEM_DIN),
        .MEM_DOUT(MEM_DOUT)
    );

    always #5 CLK96 = ~CLK96;

    function automatic logic [15:0] init_word(input logic [11:0] a);
        case (a)
            12'h123: init_word = 16'hA5C3;
            12'h124: init_word = 16'h3C5A;
            12'h125: init_word = 16'h0F0F;
            12'h126: init_word = 16'hF00D;
            12'h201: init_word = 16'h5555;
            default: init_word = 16'h0000;
        endcase
    endfunction

    // Memory output registered once after the address is seen.
    always @(posedge CLK96) begin
        if (RESET96) begin
            for (int a = 0; a < 4096; a++) mem[a] <= init_word(12'(a));
        end else if (MEM_WE) begin
            if (MEM_BE[1]) mem[MEM_ADDR][15:8] <= MEM_DIN[15:8];
            if (MEM_BE[0]) mem[MEM_ADDR][7:0]  <= MEM_DIN[7:0];
        end
        MEM_DOUT <= mem[MEM_ADDR];
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge CLK96);
        #1;
    endtask

    task automatic sample();
        @(negedge CLK96);
    endtask

    initial begin
        pat[0] = 16'hA5C3;
        pat[1] = 16'h3C5A;
        pat[2] = 16'h0F0F;
        pat[3] = 16'hF00D;

        // Reset state
        tick();
        tick();
        sample();
        check("rst_ren_valid", 32'(REN_VALID), 32'd0);
        check("rst_ren_data", 32'(REN_DATA), 32'd0);
        check("rst_ren_gnt", 32'(REN_GNT), 32'd0);
        check("rst_cpu_ack", 32'(CPU_ACK), 32'd0);
        check("rst_cpu_dout", 32'(CPU_DOUT), 32'd0);
        check("rst_mem_addr", 32'(MEM_ADDR), 32'd0);
        check("rst_mem_we", 32'(MEM_WE), 32'd0);
        check("rst_mem_be", 32'(MEM_BE), 32'd0);
        check("rst_mem_din", 32'(MEM_DIN), 32'd0);

        // In-flight renderer read dropped by reset
        tick();
        RESET96 = 1'b0;
        REN_REQ = 1'b1;
        REN_ADDR = 12'h010;
        sample();
        check("drop_gnt", 32'(REN_GNT), 32'd1);
        tick();
        REN_REQ = 1'b0;
        RESET96 = 1'b1;
        sample();
        check("drop_issue_addr", 32'(MEM_ADDR), 32'h010);
        tick();
        RESET96 = 1'b0;
        sample();
        check("drop_addr_cleared", 32'(MEM_ADDR), 32'd0);
        for (int i = 0; i < 5; i++) begin
            tick();
            sample();
            check("drop_no_valid", 32'(REN_VALID), 32'd0);
        end

        // Renderer alone: four back-to-back reads
        for (int i = 0; i < 8; i++) begin
            tick();
            REN_REQ = (i < 4);
            REN_ADDR = 12'(12'h123 + i);
            sample();
            check("ren_gnt", 32'(REN_GNT), 32'(i < 4));
            check("ren_valid", 32'(REN_VALID), 32'(i >= 3 && i <= 6));
            if (i >= 3 && i <= 6) check("ren_data", 32'(REN_DATA), 32'(pat[i-3]));
            if (i == 1) begin
                check("ren_mem_addr", 32'(MEM_ADDR), 32'h123);
                check("ren_mem_be", 32'(MEM_BE), 32'd3);
                check("ren_mem_we", 32'(MEM_WE), 32'd0);
            end
        end

        // CPU write with upper byte enable only
        tick();
        REN_REQ = 1'b0;
        CPU_REQ = 1'b1;
        CPU_WE = 1'b1;
        CPU_ADDR = 12'h040;
        CPU_DIN = 16'hBEEF;
        CPU_BE = 2'b10;
        sample();
        check("wr_no_gnt_ren", 32'(REN_GNT), 32'd0);
        check("wr_ack_early", 32'(CPU_ACK), 32'd0);
        tick();
        CPU_REQ = 1'b0;
        CPU_WE = 1'b0;
        sample();
        check("wr_ack", 32'(CPU_ACK), 32'd1);
        check("wr_mem_we", 32'(MEM_WE), 32'd1);
        check("wr_mem_addr", 32'(MEM_ADDR), 32'h040);
        check("wr_mem_din", 32'(MEM_DIN), 32'hBEEF);
        check("wr_mem_be", 32'(MEM_BE), 32'd2);

        // CPU read held across its ACK: second grant only the cycle after
        tick();
        CPU_REQ = 1'b1;
        CPU_WE = 1'b0;
        CPU_ADDR = 12'h040;
        sample();
        check("wr_we_one_cycle", 32'(MEM_WE), 32'd0);
        check("rd_ack_idle", 32'(CPU_ACK), 32'd0);
        for (int j = 1; j <= 7; j++) begin
            tick();
            if (j == 7) CPU_REQ = 1'b0;
            sample();
            check("rd_ack", 32'(CPU_ACK), 32'(j == 3 || j == 7));
            check("rd_dout", 32'(CPU_DOUT), (j < 3) ? 32'h0000 : 32'hBE00);
            if (j == 1) check("rd_mem_addr", 32'(MEM_ADDR), 32'h040);
        end

        // Contention: renderer continuous, CPU forced every STARVE_MAX losses
        for (int i = 0; i < 24; i++) begin
            tick();
            REN_REQ = 1'b1;
            REN_ADDR = 12'h300;
            CPU_REQ = (i < 23);
            CPU_WE = 1'b0;
            CPU_ADDR = 12'h124;
            sample();
            check("cont_ren_gnt", 32'(REN_GNT), 32'(!(i == 8 || i == 20)));
            check("cont_cpu_ack", 32'(CPU_ACK), 32'(i == 11 || i == 23));
            check("cont_ren_valid", 32'(REN_VALID), 32'(i >= 3 && i != 11 && i != 23));
            if (i == 9) check("cont_mem_addr", 32'(MEM_ADDR), 32'h124);
            if (i == 11) check("cont_cpu_dout", 32'(CPU_DOUT), 32'h3C5A);
        end
        tick();
        REN_REQ = 1'b0;
        CPU_REQ = 1'b0;
        for (int i = 0; i < 4; i++) tick();

        // CPU write then renderer read of the same address
        CPU_REQ = 1'b1;
        CPU_WE = 1'b1;
        CPU_ADDR = 12'h200;
        CPU_DIN = 16'h1234;
        CPU_BE = 2'b11;
        sample();
        check("ord_wr_no_ren", 32'(REN_GNT), 32'd0);
        tick();
        CPU_REQ = 1'b0;
        CPU_WE = 1'b0;
        REN_REQ = 1'b1;
        REN_ADDR = 12'h200;
        sample();
        check("ord_ren_gnt", 32'(REN_GNT), 32'd1);
        check("ord_wr_ack", 32'(CPU_ACK), 32'd1);
        tick();
        REN_REQ = 1'b0;
        tick();
        sample();
        check("ord_valid_early", 32'(REN_VALID), 32'd0);
        tick();
        sample();
        check("ord_valid", 32'(REN_VALID), 32'd1);
        check("ord_data", 32'(REN_DATA), 32'h1234);

        // Renderer read then CPU write of the same address
        tick();
        REN_REQ = 1'b1;
        REN_ADDR = 12'h201;
        sample();
        check("rev_ren_gnt", 32'(REN_GNT), 32'd1);
        tick();
        REN_REQ = 1'b0;
        CPU_REQ = 1'b1;
        CPU_WE = 1'b1;
        CPU_ADDR = 12'h201;
        CPU_DIN = 16'h9999;
        CPU_BE = 2'b11;
        sample();
        check("rev_ack_early", 32'(CPU_ACK), 32'd0);
        tick();
        CPU_REQ = 1'b0;
        CPU_WE = 1'b0;
        sample();
        check("rev_wr_ack", 32'(CPU_ACK), 32'd1);
        tick();
        sample();
        check("rev_valid", 32'(REN_VALID), 32'd1);
        check("rev_data", 32'(REN_DATA), 32'h5555);

        // Write with no byte enables: slot used, acknowledged, memory unchanged
        tick();
        CPU_REQ = 1'b1;
        CPU_WE = 1'b1;
        CPU_ADDR = 12'h124;
        CPU_DIN = 16'hFFFF;
        CPU_BE = 2'b00;
        sample();
        tick();
        CPU_REQ = 1'b0;
        CPU_WE = 1'b0;
        REN_REQ = 1'b1;
        REN_ADDR = 12'h124;
        sample();
        check("be0_ack", 32'(CPU_ACK), 32'd1);
        check("be0_mem_we", 32'(MEM_WE), 32'd1);
        check("be0_mem_be", 32'(MEM_BE), 32'd0);
        check("be0_ren_gnt", 32'(REN_GNT), 32'd1);
        tick();
        REN_REQ = 1'b0;
        tick();
        tick();
        sample();
        check("be0_valid", 32'(REN_VALID), 32'd1);
        check("be0_data", 32'(REN_DATA), 32'h3C5A);

        tick();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
